// File: rtl/fifo_param.sv
// fifo_param: synchronous FIFO with registered read data, count-decoded status flags and error flag.
// FIFO_STICKY_ERROR_EN: error_fifo_out latches until reset instead of pulsing one cycle.
module fifo_param #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] fifo_data_in,
  input  logic                 fifo_write,
  input  logic                 fifo_read,
  input  logic [ADDR_BITS:0]   almost_full_thr,
  input  logic [ADDR_BITS:0]   almost_empty_thr,
  output logic [DATA_BITS-1:0] fifo_data_out,
  output logic                 fifo_valid_out,
  output logic                 fifo_full_out,
  output logic                 fifo_empty_out,
  output logic                 fifo_almost_full_out,
  output logic                 fifo_almost_empty_out,
  output logic [ADDR_BITS:0]   fifo_count_out,
  output logic                 error_fifo_out
);
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS:0] DEPTH_C = DEPTH[ADDR_BITS:0];
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic                 rd_acc, wr_acc, err_ev;
  always_comb begin
    rd_acc = fifo_read && !fifo_empty_out;
    wr_acc = fifo_write && (!fifo_full_out || rd_acc);
    err_ev = (fifo_write && fifo_full_out && !rd_acc) || (fifo_read && fifo_empty_out);
  end
  assign fifo_count_out        = count;
  assign fifo_full_out         = count == DEPTH_C;
  assign fifo_empty_out        = count == '0;
  assign fifo_almost_full_out  = count >= almost_full_thr;
  assign fifo_almost_empty_out = count <= almost_empty_thr;
  // Storage is deliberately left out of reset.
  always_ff @(posedge clk)
    if (!reset && wr_acc) mem[wr_ptr] <= fifo_data_in;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      fifo_data_out  <= '0;
      fifo_valid_out <= 1'b0;
      error_fifo_out <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (rd_acc) begin
        rd_ptr        <= rd_ptr + ADDR_BITS'(1);
        fifo_data_out <= mem[rd_ptr];
      end
      fifo_valid_out <= rd_acc;
      count <= (wr_acc && !rd_acc) ? count + (ADDR_BITS+1)'(1) :
               (rd_acc && !wr_acc) ? count - (ADDR_BITS+1)'(1) : count;
`ifdef FIFO_STICKY_ERROR_EN
      error_fifo_out <= error_fifo_out || err_ev;
`else
      error_fifo_out <= err_ev;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: queue-model checked FIFO bench with directed vectors and literal spot checks.
module tb_fifo_param;
  localparam int DEPTH = 8;
  logic       clk = 0, reset = 0, fifo_write = 0, fifo_read = 0;
  logic [9:0] fifo_data_in = '0, fifo_data_out;
  logic [3:0] almost_full_thr = 4'd6, almost_empty_thr = 4'd2, fifo_count_out;
  logic       fifo_valid_out, fifo_full_out, fifo_empty_out, fifo_almost_full_out, fifo_almost_empty_out, error_fifo_out;
  int n_chk = 0, n_fail = 0;
  logic [9:0] q[$];
  logic [9:0] m_data;
  logic m_valid, m_err, started = 0;
  fifo_param #(.DATA_BITS(10), .ADDR_BITS(3)) dut (
    .clk(clk), .reset(reset), .fifo_data_in(fifo_data_in), .fifo_write(fifo_write), .fifo_read(fifo_read),
    .almost_full_thr(almost_full_thr), .almost_empty_thr(almost_empty_thr), .fifo_data_out(fifo_data_out),
    .fifo_valid_out(fifo_valid_out), .fifo_full_out(fifo_full_out), .fifo_empty_out(fifo_empty_out),
    .fifo_almost_full_out(fifo_almost_full_out), .fifo_almost_empty_out(fifo_almost_empty_out),
    .fifo_count_out(fifo_count_out), .error_fifo_out(error_fifo_out));
  initial forever #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    if (reset) begin
      q.delete(); m_data = '0; m_valid = 0; m_err = 0; started = 1;
    end else begin
      automatic int sz = q.size();
      automatic bit rd = fifo_read && sz > 0;
      automatic bit wr = fifo_write && (sz < DEPTH || rd);
      automatic bit er = (fifo_write && sz == DEPTH && !rd) || (fifo_read && sz == 0);
      m_valid = rd;
      if (rd) m_data = q.pop_front();
      if (wr) q.push_back(fifo_data_in);
`ifdef FIFO_STICKY_ERROR_EN
      m_err = m_err || er;
`else
      m_err = er;
`endif
    end
  end
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("model_count", 32'(fifo_count_out), 32'(q.size()));
      chk("model_full", 32'(fifo_full_out), 32'(q.size() == DEPTH));
      chk("model_empty", 32'(fifo_empty_out), 32'(q.size() == 0));
      chk("model_afull", 32'(fifo_almost_full_out), 32'(q.size() >= int'(almost_full_thr)));
      chk("model_aempty", 32'(fifo_almost_empty_out), 32'(q.size() <= int'(almost_empty_thr)));
      chk("model_valid", 32'(fifo_valid_out), 32'(m_valid));
      chk("model_data", 32'(fifo_data_out), 32'(m_data));
      chk("model_err", 32'(error_fifo_out), 32'(m_err));
    end
  end
  task automatic cyc(input logic w, input logic r, input logic [9:0] d);
    fifo_write = w; fifo_read = r; fifo_data_in = d;
    @(posedge clk); #1;
    fifo_write = 0; fifo_read = 0;
  endtask
  task automatic do_reset();
    reset = 1; cyc(0, 0, '0); reset = 0;
  endtask
  initial begin
    #1;
    do_reset();
    chk("rst_count", 32'(fifo_count_out), 0);
    chk("rst_empty", 32'(fifo_empty_out), 1);
    chk("rst_full", 32'(fifo_full_out), 0);
    chk("rst_valid", 32'(fifo_valid_out), 0);
    chk("rst_data", 32'(fifo_data_out), 0);
    chk("rst_err", 32'(error_fifo_out), 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(1, 0, 10'(i));
      chk("fill_count", 32'(fifo_count_out), 32'(i));
      chk("fill_aempty", 32'(fifo_almost_empty_out), 32'(i <= 2));
      chk("fill_afull", 32'(fifo_almost_full_out), 32'(i >= 6));
    end
    chk("fill_full", 32'(fifo_full_out), 1);
    cyc(1, 0, 10'h3FF);
    chk("ovf_count", 32'(fifo_count_out), 8);
    chk("ovf_err", 32'(error_fifo_out), 1);
    cyc(0, 0, '0);
`ifdef FIFO_STICKY_ERROR_EN
    chk("ovf_err_hold", 32'(error_fifo_out), 1);
`else
    chk("ovf_err_pulse", 32'(error_fifo_out), 0);
`endif
    almost_full_thr = 4'd12; almost_empty_thr = 4'd12;
    cyc(0, 0, '0);
    chk("thr_hi_afull", 32'(fifo_almost_full_out), 0);
    chk("thr_hi_aempty", 32'(fifo_almost_empty_out), 1);
    almost_full_thr = 4'd6; almost_empty_thr = 4'd2;
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, '0);
      chk("drain_valid", 32'(fifo_valid_out), 1);
      chk("drain_data", 32'(fifo_data_out), 32'(i));
    end
    chk("drain_empty", 32'(fifo_empty_out), 1);
    cyc(0, 0, '0);
    chk("idle_valid", 32'(fifo_valid_out), 0);
    chk("idle_data_hold", 32'(fifo_data_out), 8);
    cyc(1, 1, 10'h155);
    chk("unf_valid", 32'(fifo_valid_out), 0);
    chk("unf_err", 32'(error_fifo_out), 1);
    chk("unf_count", 32'(fifo_count_out), 1);
    cyc(0, 1, '0);
    chk("unf_next_data", 32'(fifo_data_out), 32'h155);
    chk("unf_next_valid", 32'(fifo_valid_out), 1);
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 10'(32 + i));
    for (int k = 0; k < 20; k++) begin
      cyc(1, 1, 10'(512 + k));
      chk("wrap_count", 32'(fifo_count_out), 8);
      chk("wrap_err", 32'(error_fifo_out), 0);
      chk("wrap_data", 32'(fifo_data_out), k < 8 ? 32'(32 + k) : 32'(512 + k - 8));
    end
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, 0, 10'(64 + i));
    chk("burst_count", 32'(fifo_count_out), 5);
    reset = 1; cyc(1, 1, 10'h3AB); reset = 0;
    chk("mid_rst_count", 32'(fifo_count_out), 0);
    chk("mid_rst_empty", 32'(fifo_empty_out), 1);
    chk("mid_rst_valid", 32'(fifo_valid_out), 0);
    chk("mid_rst_err", 32'(error_fifo_out), 0);
    cyc(1, 0, 10'h0AA);
    cyc(0, 1, '0);
    chk("post_rst_data", 32'(fifo_data_out), 32'h0AA);
    chk("post_rst_valid", 32'(fifo_valid_out), 1);
    cyc(0, 0, '0);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
